// File: rtl/ahb_master_arbiter.sv
// Two-requester AHB-Lite master: arbitrates M0/M1 req/done handshakes onto a
// single non-pipelined master port issuing SINGLE NONSEQ transfers.
//
// state | meaning
// IDLE  | no transfer; arbitrate and latch winner's fields
// ADDR  | address phase, htrans = NONSEQ until hready
// DATA  | data phase, hwdata driven, wait for hready
// RESP  | owner's done (and err) pulse; no arbitration
module ahb_master_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [2:0]        m0_size,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [2:0]        m1_size,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t            r_state,      w_state_nxt;
    logic              r_owner,      w_owner_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
    logic [ADDR_W-1:0] r_haddr,      w_haddr_nxt;
    logic [1:0]        r_htrans,     w_htrans_nxt;
    logic              r_hwrite,     w_hwrite_nxt;
    logic [2:0]        r_hsize,      w_hsize_nxt;
    logic [DATA_W-1:0] r_hwdata,     w_hwdata_nxt;
    logic [DATA_W-1:0] r_m0_rdata,   w_m0_rdata_nxt;
    logic [DATA_W-1:0] r_m1_rdata,   w_m1_rdata_nxt;
    logic              r_m0_done,    w_m0_done_nxt;
    logic              r_m1_done,    w_m1_done_nxt;
    logic              r_m0_err,     w_m0_err_nxt;
    logic              r_m1_err,     w_m1_err_nxt;
    logic              w_pick_m1;

    // With both requesting, round-robin favours whoever was not granted last.
    assign w_pick_m1 = m1_req && (!m0_req || FIXED_PRIORITY || !r_last_grant);

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_wdata_nxt      = r_wdata;
        w_haddr_nxt      = r_haddr;
        w_htrans_nxt     = HT_IDLE;
        w_hwrite_nxt     = r_hwrite;
        w_hsize_nxt      = r_hsize;
        w_hwdata_nxt     = r_hwdata;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        w_m0_done_nxt    = 1'b0;
        w_m1_done_nxt    = 1'b0;
        w_m0_err_nxt     = 1'b0;
        w_m1_err_nxt     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_owner_nxt      = w_pick_m1;
                    w_last_grant_nxt = w_pick_m1;
                    w_haddr_nxt      = w_pick_m1 ? m1_addr  : m0_addr;
                    w_hwrite_nxt     = w_pick_m1 ? m1_write : m0_write;
                    w_hsize_nxt      = w_pick_m1 ? m1_size  : m0_size;
                    w_wdata_nxt      = w_pick_m1 ? m1_wdata : m0_wdata;
                    w_htrans_nxt     = HT_NONSEQ;
                    w_state_nxt      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    w_hwdata_nxt = r_wdata;
                    w_state_nxt  = ST_DATA;
                end else begin
                    w_htrans_nxt = HT_NONSEQ;
                end
            end
            ST_DATA: begin
                // hready low covers both slave waits and the first ERROR cycle.
                if (hready) begin
                    w_state_nxt = ST_RESP;
                    if (r_owner) begin
                        w_m1_done_nxt = 1'b1;
                        w_m1_err_nxt  = hresp;
                        if (!r_hwrite) w_m1_rdata_nxt = hrdata;
                    end else begin
                        w_m0_done_nxt = 1'b1;
                        w_m0_err_nxt  = hresp;
                        if (!r_hwrite) w_m0_rdata_nxt = hrdata;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wdata      <= '0;
            r_haddr      <= '0;
            r_htrans     <= HT_IDLE;
            r_hwrite     <= 1'b0;
            r_hsize      <= '0;
            r_hwdata     <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_done    <= 1'b0;
            r_m1_done    <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_wdata      <= w_wdata_nxt;
            r_haddr      <= w_haddr_nxt;
            r_htrans     <= w_htrans_nxt;
            r_hwrite     <= w_hwrite_nxt;
            r_hsize      <= w_hsize_nxt;
            r_hwdata     <= w_hwdata_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_m0_done    <= w_m0_done_nxt;
            r_m1_done    <= w_m1_done_nxt;
            r_m0_err     <= w_m0_err_nxt;
            r_m1_err     <= w_m1_err_nxt;
        end
    end

    assign haddr    = r_haddr;
    assign htrans   = r_htrans;
    assign hwrite   = r_hwrite;
    assign hsize    = r_hsize;
    assign hburst   = 3'b000;
    assign hwdata   = r_hwdata;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign m0_done  = r_m0_done;
    assign m1_done  = r_m1_done;
    assign m0_err   = r_m0_err;
    assign m1_err   = r_m1_err;

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the single AHB-Lite master port between two requesters: M0 (instruction fetch) and M1 (data memory).
- Each requester uses a simple req/done handshake. The block arbitrates between them, sequences the AHB address and data phases, and returns read data or an error to the granted requester.
- Its AHB outputs drive the master side of the bus multiplexor.
- Transfers are non-pipelined: one transaction is in flight at a time, and every transfer is SINGLE.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIXED_PRIORITY, 0. 0 = round-robin; 1 = M1 always wins when both request.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  M0 transfer request; held high with fields stable until m0_done.
- m0_addr  in  ADDR_W  M0 byte address.
- m0_write  in  1  1 = write, 0 = read.
- m0_size  in  3  HSIZE encoding (0 = byte, 1 = half, 2 = word).
- m0_wdata  in  DATA_W  M0 write data.
- m0_rdata  out  DATA_W  M0 read data; valid while m0_done = 1.
- m0_done  out  1  one-cycle completion pulse.
- m0_err  out  1  high with m0_done if the slave returned ERROR.
- m1_req, m1_addr, m1_write, m1_size, m1_wdata, m1_rdata, m1_done, m1_err: same as the M0 ports, for M1.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type; only IDLE = 2'b00 and NONSEQ = 2'b10 are used.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size.
- hburst  out  3  fixed 3'b000 (SINGLE).
- hwdata  out  DATA_W  AHB write data.
- hrdata  in  DATA_W  AHB read data.
- hready  in  1  AHB ready from the multiplexor.
- hresp  in  1  AHB response; 1 = ERROR.

Behaviour:
- All outputs are registered.
- Reset values: haddr, hwrite, hsize, hburst, hwdata = 0; htrans = IDLE; m*_rdata = 0; m*_done = 0; m*_err = 0; state = IDLE; last_grant = M1.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - htrans = IDLE.
  - If any req is high, pick a winner and latch its addr, write, size and wdata into the bus registers. Next state is ADDR.
  - No request: stay in IDLE.
- Arbitration rule:
  - Only one requester: that requester wins.
  - Both request, FIXED_PRIORITY = 1: M1 wins.
  - Both request, FIXED_PRIORITY = 0: the master not in last_grant wins.
  - last_grant is updated at the grant.
- ADDR:
  - htrans = NONSEQ; haddr, hwrite and hsize come from the latched values.
  - If hready = 1, go to DATA. Otherwise hold all address-phase outputs unchanged.
- DATA:
  - htrans = IDLE; hwdata = latched wdata, held through wait states.
  - hready = 0 with hresp = 1 is the first cycle of an error response: keep waiting.
  - On hready = 1, go to RESP. At the same edge, capture hrdata into the owner's rdata (reads only) and hresp into the owner's err.
- RESP:
  - The owner's done = 1 for exactly this cycle; its err is valid only in this cycle.
  - No arbitration takes place in RESP, so a req still high during the done cycle is never re-granted.
  - Next state is IDLE. A req high in IDLE is a new transaction.
- Latency: with zero wait states, req sampled in IDLE at cycle 0 gives ADDR at cycle 1, DATA at cycle 2 and done at cycle 3. Each slave wait state adds one cycle. Back-to-back transfers take 4 cycles each.
- m*_rdata for the owner updates only on a completed read and holds otherwise. The non-owner's done, err and rdata are unchanged.
- A requester dropping req mid-transfer is a protocol violation. The transfer still completes and done is still pulsed.
- Reset asserted in any state: on the next edge, return to the reset values. An in-flight transfer is abandoned with no done pulse, and htrans is IDLE in the following cycle.

Test Plan:
- Single M0 read at 0x0000_0010, RAM returns 0xDEADBEEF with zero waits -> htrans NONSEQ in cycle 1 only; m0_done in cycle 3 with m0_rdata = 0xDEADBEEF and m0_err = 0.
- M1 word write of 0x12345678 to 0x0000_0100 with 2 wait states in the data phase -> hwdata = 0x12345678 held for 3 cycles; m1_done in cycle 5; m0 outputs untouched.
- M0 and M1 both request continuously, FIXED_PRIORITY = 0 -> grants alternate M0, M1, M0, M1 (M0 first after reset), each 4 cycles apart; with FIXED_PRIORITY = 1 -> M1 is granted every time.
- M1 read to 0x0002_0000 (default slave): hresp = 1 with hready = 0, then hresp = 1 with hready = 1 -> m1_done = 1 and m1_err = 1 for one cycle; the next transfer starts cleanly.
- rst pulsed during DATA with hready held low -> next cycle htrans = IDLE, all outputs at reset values, no done pulse; a fresh M0 request then completes normally.
- req kept high through the done cycle, then dropped -> exactly one transfer issued, with no duplicate NONSEQ.
